fpu_instr_issue: RTL and testbench
==================================

# fpu_instr_issue

Instruction issue sequencer sitting in front of the half-precision FPU decode stage. It buffers 32-bit instruction words written by the host, classifies each by opcode, and presents it to the decode stage on `Instruction` with the matching control (`Activation_Signal`, `fpu_active`). It then holds the word until the execute path signals completion, so the decode stage only ever sees one in-flight instruction.

## Interface
Parameters:
- `DEPTH`, 8: instruction queue entries; power of two, 2..64.
- `AW`, 3: log2(DEPTH).

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_l`  in  1  asynchronous, active-low reset.
- `host_wr_en`  in  1  push `host_wr_data` into the queue.
- `host_wr_data`  in  32  instruction word.
- `host_full`  out  1  queue full; a push while full is dropped.
- `host_count`  out  AW+1  number of occupied entries.
- `start`  in  1  one-cycle pulse that begins draining the queue.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the queue has drained.
- `error`  out  1  sticky; cleared by `start` or reset.
- `retired_count`  out  16  instructions retired since `start`; saturates at 16'hFFFF.
- `Instruction`  out  32  word presented to decode; 32'h0 when not issuing.
- `Activation_Signal`  out  1  integer-result writeback strobe.
- `fpu_active`  out  1  FP instruction in flight.
- `fpu_complete`  in  1  FP execution finished (single-cycle pulse).
- `halt_req`  in  1  decoder requests issue stall.
- `illegal_config`  in  1  decoder rejected the current FP instruction.

## Operation
- **Reset values:** all outputs are 0, the queue is empty, and the state is IDLE.
- **Queue:** circular FIFO with read and write pointers that wrap at DEPTH.
  - A push and a pop in the same cycle are both honoured and `host_count` is unchanged.
  - A push when full is ignored and does not set `error`.
- **FSM states:** IDLE, FETCH, EXEC_INT, EXEC_CSR, EXEC_FP, DONE.
- **IDLE:**
  - `start` moves to FETCH, clears `error`, and zeroes `retired_count`.
  - `start` is ignored in all other states.
- **FETCH:**
  - Queue empty: go to DONE.
  - `halt_req` high: stay in FETCH with no pop.
  - Otherwise pop the head into the instruction register and classify it on `[6:0]`:
    - 0010011, 0110111, 0010000: go to EXEC_INT.
    - 1110011: go to EXEC_CSR.
    - 0000111, 0100111, 1000011, 1000111, 1001011, 1001111, 1010011: go to EXEC_FP.
    - Any other opcode: set `error`, drop the word (not retired), stay in FETCH.
- **EXEC_INT:** drive the word with `Activation_Signal`=1 for exactly 1 cycle, retire it, return to FETCH.
- **EXEC_CSR:** drive the word for 2 cycles with `Activation_Signal`=0, so the decode stage's registered CSR read can write back. Then retire and return to FETCH.
- **EXEC_FP:** drive the word with `fpu_active`=1 until one of:
  - `fpu_complete`=1: retire and return to FETCH.
  - `illegal_config`=1 with no `fpu_complete` in the same cycle: set `error`, flush the queue, go to IDLE. The instruction is not retired.
  - `fpu_complete` wins if both are high in the same cycle.
- **DONE:** pulse `done` for 1 cycle, go to IDLE.
- **Reset mid-operation:** the asynchronous reset clears everything immediately, including any in-flight instruction, and no completion is reported.
- **Host pushes during operation:** allowed; the new words are issued in order.

## Timing
- From `start`, the first word appears on `Instruction` 2 cycles later (IDLE→FETCH, FETCH→EXEC).
- Each classified instruction costs one FETCH cycle plus its execute cycles:
  - integer: 2 cycles total.
  - CSR: 3 cycles total.
  - FP: 1 + N cycles, where N counts EXEC_FP cycles up to and including the one with `fpu_complete`.
- `Instruction`, `Activation_Signal` and `fpu_active` are registered outputs, glitch-free, and change only on state entry or exit.
- `halt_req` is sampled only in FETCH. An instruction already issued is never stalled or aborted by `halt_req`.
- `done` follows the last retirement by 2 cycles (FETCH sees empty, then DONE).

## Configuration
- **`FPU_ISSUE_TIMEOUT_EN` defined:** a 10-bit watchdog counts EXEC_FP cycles.
  - It resets on entry to EXEC_FP.
  - If it reaches 1023 without `fpu_complete`: set `error`, drop `fpu_active`, flush the queue, go to IDLE.
- **Macro undefined:** EXEC_FP waits indefinitely; the counter logic is absent.

## Structure
- **Shared package:**
  - FSM state enum.
  - Opcode constants: OP_IMM, LUI, RESET_OP, SYSTEM, FLH, FSH, FMADD, FMSUB, FNMSUB, FNMADD, OP_FP.
  - Watchdog limit 1023.
- **Sub-module:** one, `fpu_issue_fifo` (DEPTH×32 circular buffer with count/full/empty). The FSM, classifier and retire counter stay in the top module.

## Test plan
- **Integer then FP:** push 32'h00500093 then 32'h00208053, `start`, `fpu_complete` pulsed 4 cycles into EXEC_FP → `Activation_Signal` high for 1 cycle with 32'h00500093; `fpu_active` high for 4 cycles with 32'h00208053; `retired_count`=2; `done` pulses 2 cycles after the FP retirement.
- **Full and simultaneous push:**
  - Push 9 words with DEPTH=8 → `host_full`=1, `host_count`=8, 9th word dropped.
  - Push during a pop → count unchanged.
- **CSR hold:** push 32'h00101073, `start` → `Instruction` held 2 cycles, `Activation_Signal`=0 throughout, `retired_count`=1.
- **Halt stall:** `halt_req` high for 5 cycles while in FETCH → no pop and `Instruction`=0; the issue resumes 1 cycle after `halt_req` falls.
- **Unknown opcode:** push 32'h0000007F → `error`=1, `retired_count`=0, next word still issued.
- **Abort and reset:**
  - `illegal_config` during EXEC_FP with 3 words queued → `error`=1, `host_count`=0, IDLE, no `done`.
  - With `FPU_ISSUE_TIMEOUT_EN`, no `fpu_complete` → same result after 1023 cycles.
  - `rst_l` low mid-EXEC_FP → all outputs 0 asynchronously.

Source files
------------

// File: rtl/fpu_instr_issue_pkg.sv
// rtl/fpu_instr_issue_pkg.sv - shared states, opcodes and limits for the FPU issue sequencer
// Optional watchdog limit is used only when FPU_ISSUE_TIMEOUT_EN is defined.
package fpu_instr_issue_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_EXEC_INT = 3'd2,
      ST_EXEC_CSR = 3'd3,
      ST_EXEC_FP  = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] RESET_OP = 7'b0010000;
   localparam logic [6:0] SYSTEM   = 7'b1110011;
   localparam logic [6:0] FLH      = 7'b0000111;
   localparam logic [6:0] FSH      = 7'b0100111;
   localparam logic [6:0] FMADD    = 7'b1000011;
   localparam logic [6:0] FMSUB    = 7'b1000111;
   localparam logic [6:0] FNMSUB   = 7'b1001011;
   localparam logic [6:0] FNMADD   = 7'b1001111;
   localparam logic [6:0] OP_FP    = 7'b1010011;

   localparam logic [9:0] WDOG_LIMIT = 10'd1023;

   // Maps an opcode to the execute state it needs; ST_IDLE marks an unknown opcode.
   function automatic state_t classify(input logic [6:0] opcode);
      state_t cls;
      case (opcode)
         OP_IMM, LUI, RESET_OP:                          cls = ST_EXEC_INT;
         SYSTEM:                                         cls = ST_EXEC_CSR;
         FLH, FSH, FMADD, FMSUB, FNMSUB, FNMADD, OP_FP:  cls = ST_EXEC_FP;
         default:                                        cls = ST_IDLE;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/fpu_instr_issue_if.sv
// rtl/fpu_instr_issue_if.sv - host push and decode-stage signals of the FPU issue sequencer
// master drives host writes and decode feedback; slave is the sequencer.
interface fpu_instr_issue_if #(
   parameter int AW = 3
);
   logic          host_wr_en;
   logic [31:0]   host_wr_data;
   logic          host_full;
   logic [AW:0]   host_count;

   logic [31:0]   Instruction;
   logic          Activation_Signal;
   logic          fpu_active;
   logic          fpu_complete;
   logic          halt_req;
   logic          illegal_config;

   modport master (
      output host_wr_en, host_wr_data, fpu_complete, halt_req, illegal_config,
      input  host_full, host_count, Instruction, Activation_Signal, fpu_active
   );

   modport slave (
      input  host_wr_en, host_wr_data, fpu_complete, halt_req, illegal_config,
      output host_full, host_count, Instruction, Activation_Signal, fpu_active
   );

endinterface

// File: rtl/fpu_issue_fifo.sv
// rtl/fpu_issue_fifo.sv - DEPTH x 32 circular instruction buffer with count/full/empty
// Pointers wrap naturally because DEPTH is a power of two; flush empties the buffer.
module fpu_issue_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_l,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   // Fullness is judged before this cycle's pop, so a push into a full queue is dropped.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fpu_instr_issue.sv
// rtl/fpu_instr_issue.sv - queues host instruction words and issues them one at a time to FPU decode
// Optional FPU_ISSUE_TIMEOUT_EN adds a watchdog that aborts a stuck FP instruction.
module fpu_instr_issue
   import fpu_instr_issue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic                 clk,
   input  logic                 rst_l,
   fpu_instr_issue_if.slave     bus,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [15:0]          retired_count
);

   state_t        state_q;
   state_t        state_d;
   state_t        cls;
   logic          pop;
   logic          flush;
   logic          err_set;
   logic          retire;
   logic          csr_cnt_q;
   logic [31:0]   instr_q;
   logic [31:0]   instr_d;
   logic          act_q;
   logic          fpa_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;
   logic [15:0]   ret_q;
   logic [31:0]   fifo_rdata;
   logic [AW:0]   fifo_count;
   logic          fifo_full;
   logic          fifo_empty;

`ifdef FPU_ISSUE_TIMEOUT_EN
   logic [9:0]    wdog_q;
   logic          wdog_expired;

   // Counter is held at zero outside EXEC_FP, so it starts fresh on every entry.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)                    wdog_q <= '0;
      else if (state_q == ST_EXEC_FP) wdog_q <= wdog_q + 1'b1;
      else                           wdog_q <= '0;
   end

   assign wdog_expired = (wdog_q == WDOG_LIMIT);
`endif

   fpu_issue_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .rst_l (rst_l),
      .flush (flush),
      .push  (bus.host_wr_en),
      .pop   (pop),
      .wdata (bus.host_wr_data),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign cls = classify(fifo_rdata[6:0]);

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      flush   = 1'b0;
      err_set = 1'b0;
      retire  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (fifo_empty) begin
               state_d = ST_DONE;
            end else if (!bus.halt_req) begin
               pop = 1'b1;
               // Unknown opcodes are consumed and flagged without leaving FETCH.
               if (cls == ST_IDLE) err_set = 1'b1;
               else                state_d = cls;
            end
         end
         ST_EXEC_INT: begin
            retire  = 1'b1;
            state_d = ST_FETCH;
         end
         ST_EXEC_CSR: begin
            if (csr_cnt_q) begin
               retire  = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_EXEC_FP: begin
            if (bus.fpu_complete) begin
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else if (bus.illegal_config) begin
               err_set = 1'b1;
               flush   = 1'b1;
               state_d = ST_IDLE;
            end
`ifdef FPU_ISSUE_TIMEOUT_EN
            else if (wdog_expired) begin
               err_set = 1'b1;
               flush   = 1'b1;
               state_d = ST_IDLE;
            end
`endif
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // The word register only changes on entry to or exit from an execute state.
   always_comb begin
      instr_d = '0;
      if (state_d == ST_EXEC_INT || state_d == ST_EXEC_CSR || state_d == ST_EXEC_FP) begin
         instr_d = (state_q == ST_FETCH) ? fifo_rdata : instr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q   <= ST_IDLE;
         instr_q   <= '0;
         act_q     <= 1'b0;
         fpa_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         csr_cnt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         act_q     <= (state_d == ST_EXEC_INT);
         fpa_q     <= (state_d == ST_EXEC_FP);
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= (state_d == ST_DONE);
         csr_cnt_q <= (state_q == ST_EXEC_CSR) ? ~csr_cnt_q : 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         err_q <= 1'b0;
         ret_q <= '0;
      end else if (state_q == ST_IDLE && start) begin
         err_q <= 1'b0;
         ret_q <= '0;
      end else begin
         if (err_set) err_q <= 1'b1;
         if (retire && ret_q != 16'hFFFF) ret_q <= ret_q + 16'd1;
      end
   end

   assign bus.host_full         = fifo_full;
   assign bus.host_count        = fifo_count;
   assign bus.Instruction       = instr_q;
   assign bus.Activation_Signal = act_q;
   assign bus.fpu_active        = fpa_q;
   assign busy                  = busy_q;
   assign done                  = done_q;
   assign error                 = err_q;
   assign retired_count         = ret_q;

endmodule

// File: tb/tb_fpu_instr_issue.sv
// tb/tb_fpu_instr_issue.sv - directed and randomized self-checking bench for fpu_instr_issue
// Reference model: a word queue plus per-opcode issue rules; FPU_ISSUE_TIMEOUT_EN selects the watchdog step.
`timescale 1ns/1ps
module tb_fpu_instr_issue;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] retired_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] model_q[$];
   logic        exp_err;
   int          exp_ret;

   fpu_instr_issue_if #(.AW(AW)) bus();

   fpu_instr_issue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk           (clk),
      .rst_l         (rst_l),
      .bus           (bus),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .retired_count (retired_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // 0 = unknown, 1 = integer, 2 = CSR, 3 = FP
   function automatic int kind_of(input logic [31:0] w);
      case (w[6:0])
         7'h13, 7'h37, 7'h10:                      return 1;
         7'h73:                                    return 2;
         7'h07, 7'h27, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53: return 3;
         default:                                  return 0;
      endcase
   endfunction

   function automatic logic [31:0] rand_word(input bit allow_bad);
      logic [6:0]  ops [12];
      logic [31:0] r;
      int          idx;
      ops = '{7'h13, 7'h37, 7'h10, 7'h73, 7'h07, 7'h27, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53, 7'h7F};
      r   = $urandom();
      idx = allow_bad ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 10));
      return {r[31:7], ops[idx]};
   endfunction

   task automatic push(input logic [31:0] w);
      bus.host_wr_en   = 1'b1;
      bus.host_wr_data = w;
      tick();
      bus.host_wr_en   = 1'b0;
      if (model_q.size() < DEPTH) model_q.push_back(w);
   endtask

   // fp_delay 0 picks a random EXEC_FP length; push_mid pushes a word in the first pop cycle.
   task automatic drain(input int fp_delay, input bit push_mid, input int halt_cycles);
      logic [31:0] w;
      logic [31:0] nw;
      int          n;
      int          sz;
      bit          first;
      first = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_err = 1'b0;
      exp_ret = 0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_err", 32'(error), 32'd0);
      chk("start_ret", 32'(retired_count), 32'd0);
      chk("fetch_instr", bus.Instruction, 32'd0);
      while (model_q.size() > 0) begin
         if (first && halt_cycles > 0) begin
            bus.halt_req = 1'b1;
            for (int i = 0; i < halt_cycles; i++) begin
               tick();
               chk("halt_instr", bus.Instruction, 32'd0);
               chk("halt_count", 32'(bus.host_count), 32'(model_q.size()));
            end
            bus.halt_req = 1'b0;
         end
         sz = model_q.size();
         w  = model_q.pop_front();
         if (first && push_mid) begin
            nw = rand_word(1'b0);
            bus.host_wr_en   = 1'b1;
            bus.host_wr_data = nw;
            if (sz < DEPTH) model_q.push_back(nw);
         end
         first = 1'b0;
         tick();
         bus.host_wr_en = 1'b0;
         chk("pop_count", 32'(bus.host_count), 32'(model_q.size()));
         case (kind_of(w))
            0: begin
               exp_err = 1'b1;
               chk("bad_err", 32'(error), 32'd1);
               chk("bad_instr", bus.Instruction, 32'd0);
               chk("bad_ret", 32'(retired_count), 32'(exp_ret));
            end
            1: begin
               chk("int_instr", bus.Instruction, w);
               chk("int_act", 32'(bus.Activation_Signal), 32'd1);
               chk("int_fpa", 32'(bus.fpu_active), 32'd0);
               exp_ret++;
               tick();
               chk("int_ret", 32'(retired_count), 32'(exp_ret));
               chk("int_act_off", 32'(bus.Activation_Signal), 32'd0);
               chk("int_instr_off", bus.Instruction, 32'd0);
            end
            2: begin
               for (int i = 0; i < 2; i++) begin
                  chk("csr_instr", bus.Instruction, w);
                  chk("csr_act", 32'(bus.Activation_Signal), 32'd0);
                  tick();
               end
               exp_ret++;
               chk("csr_ret", 32'(retired_count), 32'(exp_ret));
               chk("csr_instr_off", bus.Instruction, 32'd0);
            end
            default: begin
               n = (fp_delay > 0) ? fp_delay : int'($urandom_range(1, 6));
               for (int i = 1; i <= n; i++) begin
                  chk("fp_instr", bus.Instruction, w);
                  chk("fp_active", 32'(bus.fpu_active), 32'd1);
                  chk("fp_act", 32'(bus.Activation_Signal), 32'd0);
                  if (i == n) begin
                     bus.fpu_complete   = 1'b1;
                     bus.illegal_config = 1'($urandom_range(0, 1));
                  end
                  tick();
               end
               bus.fpu_complete   = 1'b0;
               bus.illegal_config = 1'b0;
               exp_ret++;
               chk("fp_ret", 32'(retired_count), 32'(exp_ret));
               chk("fp_off", 32'(bus.fpu_active), 32'd0);
               chk("fp_err", 32'(error), 32'(exp_err));
            end
         endcase
      end
      chk("pre_done", 32'(done), 32'd0);
      tick();
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd1);
      tick();
      chk("done_clear", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("final_err", 32'(error), 32'(exp_err));
      chk("final_ret", 32'(retired_count), 32'(exp_ret));
   endtask

   initial begin
      int cyc;
      bit seen_done;
      int n;
      bus.host_wr_en     = 1'b0;
      bus.host_wr_data   = '0;
      bus.fpu_complete   = 1'b0;
      bus.halt_req       = 1'b0;
      bus.illegal_config = 1'b0;

      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(error), 32'd0);
      chk("rst_ret", 32'(retired_count), 32'd0);
      chk("rst_instr", bus.Instruction, 32'd0);
      chk("rst_act", 32'(bus.Activation_Signal), 32'd0);
      chk("rst_fpa", 32'(bus.fpu_active), 32'd0);
      chk("rst_full", 32'(bus.host_full), 32'd0);
      chk("rst_count", 32'(bus.host_count), 32'd0);
      rst_l = 1'b1;
      tick();

      // integer then FP with completion 4 cycles into EXEC_FP
      push(32'h00500093);
      push(32'h00208053);
      drain(4, 1'b0, 0);

      // overfill: the ninth word is dropped
      for (int i = 0; i < 9; i++) push(rand_word(1'b0));
      chk("full_flag", 32'(bus.host_full), 32'd1);
      chk("full_count", 32'(bus.host_count), 32'd8);
      drain(0, 1'b0, 0);

      // push alongside a pop leaves the count unchanged
      for (int i = 0; i < 3; i++) push(rand_word(1'b0));
      drain(0, 1'b1, 0);

      // CSR hold
      push(32'h00101073);
      drain(0, 1'b0, 0);

      // halt stall in FETCH for 5 cycles
      push(32'h00500093);
      drain(0, 1'b0, 5);

      // unknown opcode is dropped, next word still issues
      push(32'h0000007F);
      push(32'h00500093);
      drain(0, 1'b0, 0);

      // illegal_config abort with 3 words still queued
      push(32'h00208053);
      push(32'h00500093);
      push(32'h00101073);
      push(32'h00500093);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("abort_fpa", 32'(bus.fpu_active), 32'd1);
      tick();
      bus.illegal_config = 1'b1;
      tick();
      bus.illegal_config = 1'b0;
      model_q.delete();
      chk("abort_err", 32'(error), 32'd1);
      chk("abort_count", 32'(bus.host_count), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_fpa_off", 32'(bus.fpu_active), 32'd0);
      chk("abort_instr", bus.Instruction, 32'd0);
      chk("abort_ret", 32'(retired_count), 32'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen_done = seen_done | done;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);

      // no fpu_complete: watchdog abort, or indefinite wait without it
      push(32'h00208053);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      cyc = 0;
      for (int i = 0; i < 1100; i++) begin
         tick();
         if (!busy) break;
         cyc++;
      end
`ifdef FPU_ISSUE_TIMEOUT_EN
      model_q.delete();
      chk("wdog_len", 32'(cyc >= 1022), 32'd1);
      chk("wdog_busy", 32'(busy), 32'd0);
      chk("wdog_err", 32'(error), 32'd1);
      chk("wdog_fpa", 32'(bus.fpu_active), 32'd0);
      chk("wdog_count", 32'(bus.host_count), 32'd0);
      chk("wdog_ret", 32'(retired_count), 32'd0);
`else
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_fpa", 32'(bus.fpu_active), 32'd1);
      bus.fpu_complete = 1'b1;
      tick();
      bus.fpu_complete = 1'b0;
      model_q.delete();
      chk("wait_ret", 32'(retired_count), 32'd1);
      tick();
      chk("wait_done", 32'(done), 32'd1);
      tick();
      chk("wait_idle", 32'(busy), 32'd0);
`endif

      // asynchronous reset in the middle of EXEC_FP
      push(32'h00208053);
      push(32'h00500093);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2;
      rst_l = 1'b0;
      #1;
      chk("arst_instr", bus.Instruction, 32'd0);
      chk("arst_fpa", 32'(bus.fpu_active), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_count", 32'(bus.host_count), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_ret", 32'(retired_count), 32'd0);
      model_q.delete();
      tick();
      rst_l = 1'b1;
      tick();

      // randomized batches including unknown opcodes
      for (int r = 0; r < 4; r++) begin
         n = int'($urandom_range(1, 8));
         for (int i = 0; i < n; i++) push(rand_word(1'b1));
         drain(0, (r % 2) == 1, (r == 2) ? 3 : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
